// File: rtl/ifc_fork_if.sv
// Handshake bundle for the stream fork: one enqueue method (x) and two dequeue methods (a, b).
// Each *_en strobe acts only on an edge where its *_rdy is high; no *_rdy depends on any *_en in the same cycle.
interface ifc_fork_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] x_data;
    logic [1:0]       x_dest;
    logic             x_en;
    logic             x_rdy;
    logic             a_en;
    logic [WIDTH-1:0] a_data;
    logic             a_rdy;
    logic             b_en;
    logic [WIDTH-1:0] b_data;
    logic             b_rdy;
    logic [7:0]       drop_count;

    modport slave (
        input  x_data, x_dest, x_en, a_en, b_en,
        output x_rdy, a_data, a_rdy, b_data, b_rdy, drop_count
    );

    modport master (
        output x_data, x_dest, x_en, a_en, b_en,
        input  x_rdy, a_data, a_rdy, b_data, b_rdy, drop_count
    );
endinterface

// File: rtl/ifc_fork.sv
// Single-producer, dual-consumer stream fork with per-word destination mask and atomic broadcast.
// Three 2-deep FIFOs; the head of x_ff moves to a_ff/b_ff only when every selected output has room.
module ifc_fork_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enq,
    input  logic [W-1:0] din,
    input  logic         deq,
    output logic         full_n,
    output logic         empty_n,
    output logic [W-1:0] dout
);
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic [1:0]   cnt;
    logic         enq_ok;
    logic         deq_ok;

    assign full_n  = (cnt != 2'd2);
    assign empty_n = (cnt != 2'd0);
    assign enq_ok  = enq && full_n;
    assign deq_ok  = deq && empty_n;
    // e0 is always the head; it is left untouched on the last dequeue so dout holds the old word
    assign dout    = e0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            if (deq_ok && cnt == 2'd2) e0 <= e1;
            if (enq_ok) begin
                if (cnt == 2'd0 || deq_ok) e0 <= din;
                else                       e1 <= din;
            end
            case ({enq_ok, deq_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module ifc_fork #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    ifc_fork_if.slave   io
);
    logic [WIDTH+1:0] x_head;
    logic [WIDTH-1:0] head_data;
    logic [1:0]       head_mask;
    logic             x_full_n;
    logic             x_empty_n;
    logic             a_full_n;
    logic             b_full_n;
    logic             fire;
    logic             drop;
    logic [7:0]       drop_q;

    assign head_data = x_head[WIDTH-1:0];
    assign head_mask = x_head[WIDTH+1:WIDTH];

    // Output "full" is the pre-cycle view, so a same-cycle consumer dequeue never opens room
    assign fire = x_empty_n && (!head_mask[0] || a_full_n) && (!head_mask[1] || b_full_n);
    assign drop = fire && (head_mask == 2'b00);

    ifc_fork_fifo2 #(.W(WIDTH + 2)) x_ff (
        .clk(clk), .rst_n(rst_n),
        .enq(io.x_en), .din({io.x_dest, io.x_data}),
        .deq(fire),
        .full_n(x_full_n), .empty_n(x_empty_n), .dout(x_head)
    );

    ifc_fork_fifo2 #(.W(WIDTH)) a_ff (
        .clk(clk), .rst_n(rst_n),
        .enq(fire && head_mask[0]), .din(head_data),
        .deq(io.a_en),
        .full_n(a_full_n), .empty_n(io.a_rdy), .dout(io.a_data)
    );

    ifc_fork_fifo2 #(.W(WIDTH)) b_ff (
        .clk(clk), .rst_n(rst_n),
        .enq(fire && head_mask[1]), .din(head_data),
        .deq(io.b_en),
        .full_n(b_full_n), .empty_n(io.b_rdy), .dout(io.b_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       drop_q <= 8'd0;
        else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end

    assign io.x_rdy      = x_full_n;
    assign io.drop_count = drop_q;
endmodule

// File: tb/tb_ifc_fork.sv
// Directed bench for ifc_fork: driver tasks push expected words, a negedge monitor pops and compares.
module tb_ifc_fork;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   a_pops = 0;
    int   b_pops = 0;
    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];

    ifc_fork_if #(.WIDTH(W)) bus ();

    ifc_fork #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.a_en && bus.a_rdy) begin
            a_pops++;
            total++;
            if (exp_a_q.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected: got 0x%0h want none", bus.a_data);
            end else begin
                logic [W-1:0] e;
                e = exp_a_q.pop_front();
                if (bus.a_data !== e) begin
                    bad++;
                    $display("FAIL a_data: got 0x%0h want 0x%0h", bus.a_data, e);
                end
            end
        end
        if (rst_n === 1'b1 && bus.b_en && bus.b_rdy) begin
            b_pops++;
            total++;
            if (exp_b_q.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected: got 0x%0h want none", bus.b_data);
            end else begin
                logic [W-1:0] e;
                e = exp_b_q.pop_front();
                if (bus.b_data !== e) begin
                    bad++;
                    $display("FAIL b_data: got 0x%0h want 0x%0h", bus.b_data, e);
                end
            end
        end
    end

    // driver: holds x_en until accepted, pushes expectations, reports cycles spent blocked
    task automatic send(input logic [W-1:0] d, input logic [1:0] m, output int waits);
        logic ok;
        ok = 1'b0;
        waits = 0;
        bus.x_data = d;
        bus.x_dest = m;
        bus.x_en = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (bus.x_rdy) begin
                ok = 1'b1;
                if (m[0]) exp_a_q.push_back(d);
                if (m[1]) exp_b_q.push_back(d);
            end else begin
                waits++;
            end
            tick();
        end
        bus.x_en = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        bus.a_en = 1'b1;
        bus.b_en = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (exp_a_q.size() == 0 && exp_b_q.size() == 0 && !bus.a_rdy && !bus.b_rdy) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int w;
        int max_w;
        int a0;
        logic seen;
        rst_n = 1'b0;
        bus.x_data = '0;
        bus.x_dest = 2'b00;
        bus.x_en = 1'b0;
        bus.a_en = 1'b0;
        bus.b_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x_rdy", {31'd0, bus.x_rdy}, 32'd1);
        check("rst_a_rdy", {31'd0, bus.a_rdy}, 32'd0);
        check("rst_b_rdy", {31'd0, bus.b_rdy}, 32'd0);
        check("rst_a_data", {24'd0, bus.a_data}, 32'd0);
        check("rst_drop", {24'd0, bus.drop_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // broadcast with latency and throughput checks
        bus.a_en = 1'b1;
        bus.b_en = 1'b1;
        check("bc_x_rdy", {31'd0, bus.x_rdy}, 32'd1);
        bus.x_en = 1'b1; bus.x_dest = 2'b11; bus.x_data = 8'h11;
        exp_a_q.push_back(8'h11); exp_b_q.push_back(8'h11);
        tick();
        bus.x_data = 8'h22;
        exp_a_q.push_back(8'h22); exp_b_q.push_back(8'h22);
        check("bc_lat_n", {31'd0, bus.a_rdy}, 32'd0);
        tick();
        bus.x_data = 8'h33;
        exp_a_q.push_back(8'h33); exp_b_q.push_back(8'h33);
        check("bc_lat_n1_a", {31'd0, bus.a_rdy}, 32'd1);
        check("bc_lat_n1_b", {31'd0, bus.b_rdy}, 32'd1);
        tick();
        bus.x_en = 1'b0;
        check("bc_tput2", {31'd0, bus.a_rdy & bus.b_rdy}, 32'd1);
        tick();
        check("bc_tput3", {31'd0, bus.a_rdy & bus.b_rdy}, 32'd1);
        tick();
        check("bc_empty", {31'd0, bus.a_rdy | bus.b_rdy}, 32'd0);
        check("bc_hold", {24'd0, bus.a_data}, 32'h33);
        drain("bc_drain");

        // steering
        send(8'hA0, 2'b01, w);
        send(8'hB0, 2'b10, w);
        send(8'hC0, 2'b11, w);
        drain("steer_drain");

        // backpressure on b
        bus.a_en = 1'b1;
        bus.b_en = 1'b0;
        a0 = a_pops;
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 2'b11, w);
        repeat (3) tick();
        check("bp_x_rdy", {31'd0, bus.x_rdy}, 32'd0);
        check("bp_b_rdy", {31'd0, bus.b_rdy}, 32'd1);
        check("bp_a_count", a_pops - a0, 32'd2);
        bus.b_en = 1'b1;
        send(8'h44, 2'b11, w);
        send(8'h45, 2'b11, w);
        drain("bp_drain");

        // head-of-line blocking
        bus.a_en = 1'b0;
        bus.b_en = 1'b1;
        send(8'h01, 2'b01, w);
        send(8'h02, 2'b01, w);
        send(8'h03, 2'b01, w);
        send(8'h55, 2'b10, w);
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen = seen | bus.b_rdy;
        end
        check("hol_b_blocked", {31'd0, seen}, 32'd0);
        bus.a_en = 1'b1;
        tick();
        bus.a_en = 1'b0;
        check("hol_b_still0", {31'd0, bus.b_rdy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            seen = bus.b_rdy;
        end
        check("hol_b_release", {31'd0, seen}, 32'd1);
        drain("hol_drain");

        // drop path
        max_w = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'(i), 2'b00, w);
            if (w > max_w) max_w = w;
        end
        repeat (3) tick();
        check("drop_10", {24'd0, bus.drop_count}, 32'd10);
        for (int i = 0; i < 290; i++) begin
            send(8'(i), 2'b00, w);
            if (w > max_w) max_w = w;
        end
        repeat (3) tick();
        check("drop_sat", {24'd0, bus.drop_count}, 32'd255);
        check("drop_xrdy_block", {31'd0, max_w <= 1}, 32'd1);
        check("drop_no_out", {31'd0, bus.a_rdy | bus.b_rdy}, 32'd0);

        // asynchronous reset mid-stream
        bus.a_en = 1'b0;
        bus.b_en = 1'b0;
        send(8'h61, 2'b11, w);
        send(8'h62, 2'b11, w);
        send(8'h63, 2'b01, w);
        repeat (2) tick();
        check("mid_a_rdy", {31'd0, bus.a_rdy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_x_rdy", {31'd0, bus.x_rdy}, 32'd1);
        check("ar_a_rdy", {31'd0, bus.a_rdy}, 32'd0);
        check("ar_b_rdy", {31'd0, bus.b_rdy}, 32'd0);
        check("ar_a_data", {24'd0, bus.a_data}, 32'd0);
        check("ar_b_data", {24'd0, bus.b_data}, 32'd0);
        check("ar_drop", {24'd0, bus.drop_count}, 32'd0);
        exp_a_q.delete();
        exp_b_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.a_en = 1'b1;
        bus.b_en = 1'b1;
        bus.x_en = 1'b1; bus.x_dest = 2'b11; bus.x_data = 8'h77;
        check("post_x_rdy", {31'd0, bus.x_rdy}, 32'd1);
        exp_a_q.push_back(8'h77); exp_b_q.push_back(8'h77);
        tick();
        bus.x_en = 1'b0;
        check("post_lat_n", {31'd0, bus.a_rdy}, 32'd0);
        tick();
        check("post_lat_a", {31'd0, bus.a_rdy}, 32'd1);
        check("post_lat_b", {31'd0, bus.b_rdy}, 32'd1);
        check("post_a_data", {24'd0, bus.a_data}, 32'h77);
        drain("post_drain");

        check("final_a_q", exp_a_q.size(), 32'd0);
        check("final_b_q", exp_b_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
